// File: rtl/unidad_salto_ras.sv
// ============================================================================
// Module   : unidad_salto_ras
// Function : ID-stage jump/branch target unit with one-slot squash and a
//            circular return-address stack (RAS) for JR prediction checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module unidad_salto_ras #(
   parameter int ANCHO_PC = 32,
   parameter int PROF_RAS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                valido,
   input  logic                stall,
   input  logic [2:0]          tipo,
   input  logic                cond,
   input  logic [25:0]         instruccion,
   input  logic [ANCHO_PC-1:0] pc4,
   input  logic [ANCHO_PC-1:0] rs_dato,
   output logic [ANCHO_PC-1:0] destino,
   output logic                redirigir,
   output logic [ANCHO_PC-1:0] pred_ra,
   output logic                ra_acierto,
   output logic                ras_vacia,
   output logic                ras_llena
);

   localparam int                  c_ANCHO_PTR = $clog2(PROF_RAS);
   localparam logic [c_ANCHO_PTR:0] c_LLENO    = PROF_RAS[c_ANCHO_PTR:0];

   localparam logic [0:0] c_REPOSO = 1'b0;
   localparam logic [0:0] c_ANULA  = 1'b1;

   localparam logic [2:0] c_T_J   = 3'b001;
   localparam logic [2:0] c_T_JAL = 3'b010;
   localparam logic [2:0] c_T_JR  = 3'b011;
   localparam logic [2:0] c_T_BR  = 3'b100;

   logic [1:0]             r_rst_sinc;
   logic                   w_rst_n;
   logic [0:0]             r_estado;
   logic [0:0]             w_estado_sig;
   logic                   w_acepta;
   logic                   w_salta;
   logic                   w_push;
   logic                   w_pop;
   logic [ANCHO_PC-1:0]    w_destino;
   logic [ANCHO_PC-1:0]    r_pila [PROF_RAS];
   logic [c_ANCHO_PTR-1:0] r_ptr;
   logic [c_ANCHO_PTR-1:0] w_tope;
   logic [c_ANCHO_PTR:0]   r_ocup;

   // Reset asserts immediately but is released only after two clock edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_rst_sinc <= 2'b00;
      else        r_rst_sinc <= {r_rst_sinc[0], 1'b1};
   end
   assign w_rst_n = r_rst_sinc[1];

   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) r_estado <= c_REPOSO;
      else          r_estado <= w_estado_sig;
   end

   always_comb begin
      w_estado_sig = r_estado;
      case (r_estado)
         c_REPOSO: if (w_salta) w_estado_sig = c_ANULA;
         c_ANULA:  if (!stall)  w_estado_sig = c_REPOSO;
         default:  w_estado_sig = c_REPOSO;
      endcase
   end

   always_comb begin
      w_acepta = valido && !stall && (r_estado == c_REPOSO);
   end

   always_comb begin
      w_salta   = 1'b0;
      w_push    = 1'b0;
      w_pop     = 1'b0;
      w_destino = '0;
      if (w_acepta) begin
         case (tipo)
            c_T_J: begin
               w_salta   = 1'b1;
               w_destino = {pc4[ANCHO_PC-1:28], instruccion, 2'b00};
            end
            c_T_JAL: begin
               w_salta   = 1'b1;
               w_push    = 1'b1;
               w_destino = {pc4[ANCHO_PC-1:28], instruccion, 2'b00};
            end
            c_T_JR: begin
               w_salta   = 1'b1;
               w_pop     = 1'b1;
               w_destino = rs_dato;
            end
            c_T_BR: begin
               w_salta   = cond;
               w_destino = pc4 + {{(ANCHO_PC-18){instruccion[15]}}, instruccion[15:0], 2'b00};
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         destino    <= '0;
         redirigir  <= 1'b0;
         ra_acierto <= 1'b0;
      end else begin
         redirigir <= w_salta;
         if (w_salta) destino <= w_destino;
         if (w_pop)   ra_acierto <= (r_ocup != '0) && (pred_ra == rs_dato);
      end
   end

   // r_ptr is the next write slot; a full push wraps over the oldest entry.
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_ptr  <= '0;
         r_ocup <= '0;
         for (int i = 0; i < PROF_RAS; i++) r_pila[i] <= '0;
      end else if (w_push) begin
         r_pila[r_ptr] <= pc4;
         r_ptr         <= r_ptr + 1'b1;
         if (r_ocup != c_LLENO) r_ocup <= r_ocup + 1'b1;
      end else if (w_pop && (r_ocup != '0)) begin
         r_ptr  <= w_tope;
         r_ocup <= r_ocup - 1'b1;
      end
   end

   assign w_tope    = r_ptr - 1'b1;
   assign pred_ra   = (r_ocup == '0) ? '0 : r_pila[w_tope];
   assign ras_vacia = (r_ocup == '0);
   assign ras_llena = (r_ocup == c_LLENO);

endmodule

`default_nettype wire

// File: tb/tb_unidad_salto_ras.sv
// ============================================================================
// Module   : tb_unidad_salto_ras
// Function : Self-checking bench for unidad_salto_ras (vector table + queue).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_unidad_salto_ras;

   typedef struct {
      logic        v, s;
      logic [2:0]  t;
      logic        c;
      logic [25:0] ins;
      logic [31:0] pc4, rs;
      logic        red;
      logic [31:0] dst, pred;
      logic        ac, vac, lle;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valido = 1'b0, stall = 1'b0, cond = 1'b0;
   logic [2:0]  tipo = 3'd0;
   logic [25:0] instruccion = '0;
   logic [31:0] pc4 = '0, rs_dato = '0;
   logic [31:0] destino, pred_ra;
   logic        redirigir, ra_acierto, ras_vacia, ras_llena;

   int   n_vec = 0;
   int   n_err = 0;
   vec_t tabla[$];
   vec_t sb[$];

   unidad_salto_ras #(.ANCHO_PC(32), .PROF_RAS(4)) dut (
      .clk(clk), .rst_n(rst_n), .valido(valido), .stall(stall), .tipo(tipo),
      .cond(cond), .instruccion(instruccion), .pc4(pc4), .rs_dato(rs_dato),
      .destino(destino), .redirigir(redirigir), .pred_ra(pred_ra),
      .ra_acierto(ra_acierto), .ras_vacia(ras_vacia), .ras_llena(ras_llena)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   function automatic vec_t vec(input logic v, s, input logic [2:0] t, input logic c,
                                input logic [25:0] ins, input logic [31:0] p, r,
                                input logic red, input logic [31:0] dst, pred,
                                input logic ac, vac, lle);
      vec_t x;
      x.v = v; x.s = s; x.t = t; x.c = c; x.ins = ins; x.pc4 = p; x.rs = r;
      x.red = red; x.dst = dst; x.pred = pred; x.ac = ac; x.vac = vac; x.lle = lle;
      return x;
   endfunction

   task automatic chk(input string nom, input int idx, input logic [31:0] act, exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s (step %0d): got %h expected %h", nom, idx, act, exp);
      end
   endtask

   task automatic comparar(input int idx);
      vec_t e;
      e = sb.pop_front();
      n_vec++;
      chk("redirigir",  idx, {31'd0, redirigir},  {31'd0, e.red});
      chk("destino",    idx, destino,             e.dst);
      chk("pred_ra",    idx, pred_ra,             e.pred);
      chk("ra_acierto", idx, {31'd0, ra_acierto}, {31'd0, e.ac});
      chk("ras_vacia",  idx, {31'd0, ras_vacia},  {31'd0, e.vac});
      chk("ras_llena",  idx, {31'd0, ras_llena},  {31'd0, e.lle});
   endtask

   task automatic aplicar(input vec_t x, input int idx);
      valido = x.v; stall = x.s; tipo = x.t; cond = x.c;
      instruccion = x.ins; pc4 = x.pc4; rs_dato = x.rs;
      sb.push_back(x);
      @(posedge clk);
      #1;
      comparar(idx);
   endtask

   task automatic ciclos_libres(input int n);
      valido = 1'b0; stall = 1'b0; tipo = 3'd0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      // Columns: v s tipo cond instr pc4 rs | red destino pred ac vacia llena
      tabla.push_back(vec(0,0,3'd0,0,26'h0,   32'h0,        32'h0,   0,32'h0,      32'h0,   0,1,0));
      tabla.push_back(vec(1,0,3'd1,0,26'h100, 32'h0040_0008,32'h0,   1,32'h400,    32'h0,   0,1,0));
      tabla.push_back(vec(1,0,3'd2,0,26'h0,   32'h1234,     32'h0,   0,32'h400,    32'h0,   0,1,0));
      tabla.push_back(vec(1,0,3'd4,1,26'hFFFE,32'h100,      32'h0,   1,32'hF8,     32'h0,   0,1,0));
      tabla.push_back(vec(0,0,3'd0,0,26'h0,   32'h0,        32'h0,   0,32'hF8,     32'h0,   0,1,0));
      tabla.push_back(vec(1,0,3'd4,0,26'hFFFE,32'h100,      32'h0,   0,32'hF8,     32'h0,   0,1,0));
      tabla.push_back(vec(1,0,3'd2,0,26'h800, 32'h2004,     32'h0,   1,32'h2000,   32'h2004,0,0,0));
      tabla.push_back(vec(0,0,3'd0,0,26'h0,   32'h0,        32'h0,   0,32'h2000,   32'h2004,0,0,0));
      tabla.push_back(vec(1,0,3'd3,0,26'h0,   32'h0,        32'h2004,1,32'h2004,   32'h0,   1,1,0));
      tabla.push_back(vec(0,0,3'd0,0,26'h0,   32'h0,        32'h0,   0,32'h2004,   32'h0,   1,1,0));
      tabla.push_back(vec(1,0,3'd3,0,26'h0,   32'h0,        32'h3000,1,32'h3000,   32'h0,   0,1,0));
      tabla.push_back(vec(0,0,3'd0,0,26'h0,   32'h0,        32'h0,   0,32'h3000,   32'h0,   0,1,0));
      // Five JALs into a four-entry stack
      tabla.push_back(vec(1,0,3'd2,0,26'h0,   32'h10,       32'h0,   1,32'h0,      32'h10,  0,0,0));
      tabla.push_back(vec(0,0,3'd0,0,26'h0,   32'h0,        32'h0,   0,32'h0,      32'h10,  0,0,0));
      tabla.push_back(vec(1,0,3'd2,0,26'h0,   32'h20,       32'h0,   1,32'h0,      32'h20,  0,0,0));
      tabla.push_back(vec(0,0,3'd0,0,26'h0,   32'h0,        32'h0,   0,32'h0,      32'h20,  0,0,0));
      tabla.push_back(vec(1,0,3'd2,0,26'h0,   32'h30,       32'h0,   1,32'h0,      32'h30,  0,0,0));
      tabla.push_back(vec(0,0,3'd0,0,26'h0,   32'h0,        32'h0,   0,32'h0,      32'h30,  0,0,0));
      tabla.push_back(vec(1,0,3'd2,0,26'h0,   32'h40,       32'h0,   1,32'h0,      32'h40,  0,0,1));
      tabla.push_back(vec(0,0,3'd0,0,26'h0,   32'h0,        32'h0,   0,32'h0,      32'h40,  0,0,1));
      tabla.push_back(vec(1,0,3'd2,0,26'h0,   32'h50,       32'h0,   1,32'h0,      32'h50,  0,0,1));
      tabla.push_back(vec(0,0,3'd0,0,26'h0,   32'h0,        32'h0,   0,32'h0,      32'h50,  0,0,1));
      // Four pops: 0x50, 0x40, 0x30 (mispredicted rs), 0x20
      tabla.push_back(vec(1,0,3'd3,0,26'h0,   32'h0,        32'h50,  1,32'h50,     32'h40,  1,0,0));
      tabla.push_back(vec(0,0,3'd0,0,26'h0,   32'h0,        32'h0,   0,32'h50,     32'h40,  1,0,0));
      tabla.push_back(vec(1,0,3'd3,0,26'h0,   32'h0,        32'h40,  1,32'h40,     32'h30,  1,0,0));
      tabla.push_back(vec(0,0,3'd0,0,26'h0,   32'h0,        32'h0,   0,32'h40,     32'h30,  1,0,0));
      tabla.push_back(vec(1,0,3'd3,0,26'h0,   32'h0,        32'h99,  1,32'h99,     32'h20,  0,0,0));
      tabla.push_back(vec(0,0,3'd0,0,26'h0,   32'h0,        32'h0,   0,32'h99,     32'h20,  0,0,0));
      tabla.push_back(vec(1,0,3'd3,0,26'h0,   32'h0,        32'h20,  1,32'h20,     32'h0,   1,1,0));
      tabla.push_back(vec(0,0,3'd0,0,26'h0,   32'h0,        32'h0,   0,32'h20,     32'h0,   1,1,0));
      // Taken J, then three stalled cycles in the squash slot with a JR waiting
      tabla.push_back(vec(1,0,3'd1,0,26'h40,  32'h0,        32'h0,   1,32'h100,    32'h0,   1,1,0));
      tabla.push_back(vec(1,1,3'd3,0,26'h0,   32'h0,        32'h77,  0,32'h100,    32'h0,   1,1,0));
      tabla.push_back(vec(1,1,3'd3,0,26'h0,   32'h0,        32'h77,  0,32'h100,    32'h0,   1,1,0));
      tabla.push_back(vec(1,1,3'd3,0,26'h0,   32'h0,        32'h77,  0,32'h100,    32'h0,   1,1,0));
      tabla.push_back(vec(1,0,3'd3,0,26'h0,   32'h0,        32'h77,  0,32'h100,    32'h0,   1,1,0));
      tabla.push_back(vec(1,0,3'd3,0,26'h0,   32'h0,        32'h77,  1,32'h77,     32'h0,   0,1,0));
      tabla.push_back(vec(0,0,3'd0,0,26'h0,   32'h0,        32'h0,   0,32'h77,     32'h0,   0,1,0));
      // Two entries on the stack, left in the squash slot for the reset test
      tabla.push_back(vec(1,0,3'd2,0,26'h0,   32'h500,      32'h0,   1,32'h0,      32'h500, 0,0,0));
      tabla.push_back(vec(0,0,3'd0,0,26'h0,   32'h0,        32'h0,   0,32'h0,      32'h500, 0,0,0));
      tabla.push_back(vec(1,0,3'd2,0,26'h20,  32'h600,      32'h0,   1,32'h80,     32'h600, 0,0,0));

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      ciclos_libres(3);

      for (int i = 0; i < tabla.size(); i++) aplicar(tabla[i], i);

      // Asynchronous reset mid-cycle while in the squash slot
      #2 rst_n = 1'b0;
      #1;
      sb.push_back(vec(0,0,3'd0,0,26'h0,32'h0,32'h0, 0,32'h0,32'h0,0,1,0));
      comparar(100);
      @(posedge clk);
      #1 rst_n = 1'b1;
      ciclos_libres(3);
      aplicar(vec(1,0,3'd1,0,26'h10,32'h0,32'h0, 1,32'h40,32'h0,0,1,0), 101);
      aplicar(vec(1,0,3'd1,0,26'h20,32'h0,32'h0, 0,32'h40,32'h0,0,1,0), 102);
      aplicar(vec(0,0,3'd0,0,26'h0, 32'h0,32'h0, 0,32'h40,32'h0,0,1,0), 103);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
